// File: rtl/pcm_stream_formatter.sv
// pcm_stream_formatter: NRZ decode, I/Q demux, LFSR derandomize, invert and format soft symbols
module pcm_stream_formatter #(
    parameter int SOFT_W = 3,
    parameter int LFSR_LEN = 15,
    parameter logic [LFSR_LEN-1:0] LFSR_TAPS = 15'h6000
) (
    input  logic              ck933,
    input  logic              rs,
    input  logic              symb_clk_en,
    input  logic              symb_clk_2x_en,
    input  logic [SOFT_W-1:0] symb_i,
    input  logic [SOFT_W-1:0] symb_q,
    input  logic [1:0]        mode,
    input  logic              demux,
    input  logic              swap,
    input  logic              derandomize,
    input  logic              data_inv,
    input  logic              sign_mag,
    output logic [SOFT_W-1:0] dout_i,
    output logic [SOFT_W-1:0] dout_q,
    output logic              dout_valid
);
    localparam int M = SOFT_W - 1;

    logic [M:0] dec_i, dec_q, s2_i, s2_q, s3_i, s3_q;
    logic [M:0] s2_i_n, s3_i_n, s3_q_n;
    logic prev_i, prev_q, load;
    logic [LFSR_LEN-1:0] shft_i, shft_q;
    logic [1:0] fill;

    function automatic logic [M:0] nrz_dec(input logic [M:0] s, input logic p, input logic [1:0] m);
        return {m == 2'd1 ? s[M] ^ p : m == 2'd2 ? ~(s[M] ^ p) : s[M], s[M-1:0]};
    endfunction

    function automatic logic [M:0] fmt(input logic [M:0] s, input logic inv, input logic sm);
        logic [M:0] v;
        v = inv ? ~s : s;
        return sm || v[M] ? v : {1'b0, ~v[M-1:0]};
    endfunction

    always_comb begin
        s2_i_n = demux && !(swap ^ symb_clk_en) ? dec_q : dec_i;
        s3_i_n = {s2_i[M] ^ (derandomize & ^(shft_i & LFSR_TAPS)), s2_i[M-1:0]};
        s3_q_n = {s2_q[M] ^ (derandomize & ~demux & ^(shft_q & LFSR_TAPS)), s2_q[M-1:0]};
        load = symb_clk_2x_en && fill == 2'd3;
    end

    // fill counts 2x events after reset so zeros still in the pipeline never show as valid data
    always_ff @(posedge ck933) begin
        if (rs) begin
            dec_i <= '0;
            dec_q <= '0;
            prev_i <= 1'b0;
            prev_q <= 1'b0;
            s2_i <= '0;
            s2_q <= '0;
            s3_i <= '0;
            s3_q <= '0;
            shft_i <= '0;
            shft_q <= '0;
            fill <= '0;
            dout_i <= '0;
            dout_q <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (symb_clk_en) begin
                dec_i <= nrz_dec(symb_i, prev_i, mode);
                dec_q <= nrz_dec(symb_q, prev_q, mode);
                prev_i <= symb_i[M];
                prev_q <= symb_q[M];
            end
            if (symb_clk_2x_en) begin
                s2_i <= s2_i_n;
                s2_q <= dec_q;
                s3_i <= s3_i_n;
                s3_q <= s3_q_n;
                shft_i <= {shft_i[LFSR_LEN-2:0], s2_i[M]};
                if (!demux) shft_q <= {shft_q[LFSR_LEN-2:0], s2_q[M]};
                if (fill != 2'd3) fill <= fill + 2'd1;
            end
            if (load) begin
                dout_i <= fmt(s3_i, data_inv, sign_mag);
                dout_q <= fmt(s3_q, data_inv, sign_mag);
            end
            dout_valid <= load;
        end
    end

    always_ff @(posedge ck933) begin
        if (!rs) assert (!(symb_clk_en && !symb_clk_2x_en));
    end
endmodule

// File: tb/tb_pcm_stream_formatter.sv
// tb_pcm_stream_formatter: directed and random stimulus against an event-indexed reference model
module tb_pcm_stream_formatter;
    logic ck933 = 1'b0;
    logic rs = 1'b1;
    logic en = 1'b0, en2 = 1'b0;
    logic [2:0] si = '0, sq = '0;
    logic [1:0] mode = '0;
    logic demux = 1'b0, swap = 1'b0, derandomize = 1'b0, data_inv = 1'b0, sign_mag = 1'b1;
    logic [2:0] dout_i, dout_q;
    logic dout_valid;

    pcm_stream_formatter dut (
        .ck933(ck933), .rs(rs), .symb_clk_en(en), .symb_clk_2x_en(en2),
        .symb_i(si), .symb_q(sq), .mode(mode), .demux(demux), .swap(swap),
        .derandomize(derandomize), .data_inv(data_inv), .sign_mag(sign_mag),
        .dout_i(dout_i), .dout_q(dout_q), .dout_valid(dout_valid)
    );

    always #5 ck933 = ~ck933;

    int n_cmp = 0, n_bad = 0;
    int k;
    logic [14:0] taps = 15'h6000;
    logic [2:0] s2i[$], s2q[$], s3i[$], s3q[$], obs[$];
    logic hi[$], hq[$];
    logic [2:0] mdec_i, mdec_q, exp_i, exp_q;
    logic mprev_i, mprev_q;

    task automatic chk(input string tag, input logic [2:0] o, input logic [2:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    function automatic logic fbm(input logic h[$]);
        logic f = 1'b0;
        for (int t = 0; t < 15; t++)
            if (taps[t] && t < h.size()) f ^= h[t];
        return f;
    endfunction

    function automatic logic [2:0] nrzm(input logic [2:0] s, input logic p, input logic [1:0] m);
        logic b = s[2];
        if (m == 2'd1) b = s[2] ^ p;
        else if (m == 2'd2) b = !(s[2] ^ p);
        return {b, s[1:0]};
    endfunction

    function automatic logic [2:0] fmtm(input logic [2:0] s, input logic inv, input logic sm);
        logic [2:0] v = inv ? ~s : s;
        if (sm || v[2]) return v;
        return {1'b0, ~v[1:0]};
    endfunction

    task automatic defaults();
        mode = 2'd0; demux = 1'b0; swap = 1'b0;
        derandomize = 1'b0; data_inv = 1'b0; sign_mag = 1'b1;
    endtask

    task automatic rst_seq(input int n);
        rs = 1'b1; en = 1'b0; en2 = 1'b0;
        repeat (n) begin
            @(posedge ck933); #1;
            chk("rst_valid", {2'b0, dout_valid}, 3'b0);
            chk("rst_dout_i", dout_i, 3'b0);
            chk("rst_dout_q", dout_q, 3'b0);
        end
        rs = 1'b0;
        k = 0;
        s2i.delete(); s2q.delete(); s3i.delete(); s3q.delete();
        hi.delete(); hq.delete(); obs.delete();
        mdec_i = '0; mdec_q = '0; mprev_i = 1'b0; mprev_q = 1'b0;
        exp_i = '0; exp_q = '0;
    endtask

    // one 2x event; the model works out stage values per event index
    task automatic ev(input logic e, input logic [2:0] i, input logic [2:0] q);
        logic [2:0] in_i, in_q, ni, nq;
        logic ev_v;
        en = e; en2 = 1'b1; si = i; sq = q;
        in_i = k > 0 ? s2i[k-1] : 3'b0;
        in_q = k > 0 ? s2q[k-1] : 3'b0;
        ni = {in_i[2] ^ (derandomize & fbm(hi)), in_i[1:0]};
        nq = demux ? in_q : {in_q[2] ^ (derandomize & fbm(hq)), in_q[1:0]};
        hi.push_front(in_i[2]);
        if (!demux) hq.push_front(in_q[2]);
        ev_v = k >= 3;
        if (ev_v) begin
            exp_i = fmtm(s3i[k-1], data_inv, sign_mag);
            exp_q = fmtm(s3q[k-1], data_inv, sign_mag);
        end
        s3i.push_back(ni);
        s3q.push_back(nq);
        s2i.push_back(demux ? ((swap ^ e) ? mdec_i : mdec_q) : mdec_i);
        s2q.push_back(mdec_q);
        if (e) begin
            mdec_i = nrzm(i, mprev_i, mode);
            mdec_q = nrzm(q, mprev_q, mode);
            mprev_i = i[2];
            mprev_q = q[2];
        end
        k++;
        @(posedge ck933); #1;
        en = 1'b0; en2 = 1'b0;
        chk("valid", {2'b0, dout_valid}, {2'b0, ev_v});
        chk("dout_i", dout_i, exp_i);
        chk("dout_q", dout_q, exp_q);
        if (ev_v) obs.push_back(dout_i);
        repeat ($urandom_range(0, 2)) begin
            @(posedge ck933); #1;
            chk("idle_valid", {2'b0, dout_valid}, 3'b0);
            chk("idle_hold_i", dout_i, exp_i);
        end
    endtask

    task automatic scen2(input logic [1:0] m, input logic [3:0] want);
        logic [2:0] pat[4] = '{3'b101, 3'b110, 3'b001, 3'b010};
        defaults(); rst_seq(1); mode = m;
        for (int n = 0; n < 4; n++) ev(1'b1, pat[n], 3'b0);
        repeat (3) ev(1'b1, 3'b0, 3'b0);
        for (int n = 0; n < 4; n++) chk("nrz_msb", {2'b0, obs[n][2]}, {2'b0, want[3-n]});
    endtask

    task automatic scen3();
        defaults(); derandomize = 1'b1;
        ev(1'b1, 3'b100, 3'b000);
        repeat (20) ev(1'b1, 3'b000, 3'b000);
        repeat (3) ev(1'b1, 3'b000, 3'b000);
        for (int n = 0; n < 21; n++)
            chk("derand_msb", {2'b0, obs[n][2]}, {2'b0, (n == 0 || n == 14 || n == 15)});
    endtask

    initial begin
        defaults();
        rst_seq(2);
        for (int n = 0; n < 40; n++) ev(1'b1, 3'($urandom), 3'($urandom));

        scen2(2'd1, 4'b1010);
        scen2(2'd2, 4'b0101);

        rst_seq(1);
        scen3();

        defaults(); rst_seq(1); sign_mag = 1'b0;
        ev(1'b1, 3'b010, 3'b000);
        ev(1'b1, 3'b110, 3'b111);
        ev(1'b1, 3'b101, 3'b011);
        ev(1'b1, 3'b000, 3'b000);
        ev(1'b1, 3'b000, 3'b000);
        data_inv = 1'b1;
        ev(1'b1, 3'b000, 3'b000);
        chk("fmt_010", obs[0], 3'b001);
        chk("fmt_110", obs[1], 3'b110);
        chk("fmt_inv_101", obs[2], 3'b001);

        for (int sw = 0; sw < 2; sw++) begin
            defaults(); rst_seq(1); demux = 1'b1; swap = sw[0];
            repeat (6) begin
                ev(1'b1, 3'b111, 3'b000);
                ev(1'b0, 3'b111, 3'b000);
            end
            for (int n = 0; n < 8; n++)
                chk("demux_phase", obs[n], ((n % 2 == 1) ^ sw[0]) ? 3'b111 : 3'b000);
        end

        defaults(); rst_seq(1);
        for (int n = 0; n < 80; n++) begin
            mode = 2'($urandom); demux = 1'($urandom); swap = 1'($urandom);
            derandomize = 1'($urandom); data_inv = 1'($urandom); sign_mag = 1'($urandom);
            ev(1'($urandom), 3'($urandom), 3'($urandom));
        end

        defaults(); mode = 2'd1; derandomize = 1'b1;
        for (int n = 0; n < 10; n++) ev(1'b1, 3'($urandom), 3'($urandom));
        rst_seq(1);
        scen3();
        scen2(2'd1, 4'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
